// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Reset and lock supervisor for the board PLL. It runs on the reference
// clock that also feeds the PLL. The block holds the PLL in reset and then
// waits for lock. System reset is released only after lock has held for a
// programmable time. A lock timeout retries the PLL, a lock loss while
// running restarts the sequence, and a sticky fail flag is set after too
// many failed attempts.
//
// Ports:
//   clk             reference clock
//   reset           synchronous, active-high reset
//   locked          PLL lock indication, asynchronous to clk
//   pll_rst         PLL reset output
//   sys_reset       active-high system reset, low only while running
//   ready           high only while running
//   fail            sticky; set when the retry budget is exhausted
//   lock_loss_count lock losses seen while running, saturating at 255
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_PLL_RST   | PLL held in reset for PLL_RST_CYCLES
// S_WAIT_LOCK | PLL released; waiting up to LOCK_TIMEOUT for lock
// S_STABLE    | lock seen; must hold for STABLE_CYCLES consecutive cycles
// S_RUN       | system reset released
// S_FAIL      | retry budget exhausted; held here until reset
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 500000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 8,
  parameter int CNT_WIDTH      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RST_LAST     = CNT_WIDTH'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [3:0]           RETRY_LIMIT  = 4'(MAX_RETRIES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           retries_q, retries_d;
  logic [7:0]           llc_q, llc_d;
  logic                 sync1_q, sync2_q;
  logic                 pll_rst_q, sys_reset_q, ready_q, fail_q;
  logic                 locked_s;

  assign locked_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    llc_d     = llc_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a timeout on the same cycle.
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retries_d = retries_q + 4'd1;
          cnt_d     = '0;
          state_d   = (retries_q + 4'd1 == RETRY_LIMIT) ? S_FAIL : S_PLL_RST;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STABLE: begin
        // A drop on the final count cycle still sends us back to waiting.
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          retries_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
          if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge
  // as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      retries_q   <= '0;
      llc_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      sync1_q     <= locked;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      llc_q       <= llc_d;
      pll_rst_q   <= (state_d == S_PLL_RST) || (state_d == S_FAIL);
      sys_reset_q <= (state_d != S_RUN);
      ready_q     <= (state_d == S_RUN);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_reset       = sys_reset_q;
  assign ready           = ready_q;
  assign fail            = fail_q;
  assign lock_loss_count = llc_q;

endmodule
